// File: rtl/ctrl_transfer_handler_pkg.sv
// Shared definitions for the control-transfer handler: next-PC select codes and FSM states.
package ctrl_transfer_handler_pkg;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_TAG = 2'b01;
   localparam logic [1:0] NPC_ALU = 2'b10;

   typedef enum logic [1:0] {
      RST_HOLD = 2'd0,
      BOOT     = 2'd1,
      RUN      = 2'd2
   } ctu_state_e;

endpackage

// File: rtl/ctu_reset_seq.sv
// Reset-release sequencer: holds the front end for RESET_HOLD cycles, then one BOOT cycle,
// then RUN.
module ctu_reset_seq
   import ctrl_transfer_handler_pkg::*;
#(
   parameter int unsigned RESET_HOLD = 2
) (
   input  logic clk,
   input  logic R_n,
   output logic hold,
   output logic boot,
   output logic run
);

   localparam int unsigned CW = $clog2(RESET_HOLD + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(RESET_HOLD - 1);

   ctu_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         state_q <= RST_HOLD;
         cnt_q   <= CNT_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold    = 1'b0;
      boot    = 1'b0;
      run     = 1'b0;
      unique case (state_q)
         RST_HOLD: begin
            hold = 1'b1;
            if (cnt_q == '0) state_d = BOOT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         BOOT: begin
            boot    = 1'b1;
            state_d = RUN;
         end
         RUN: run = 1'b1;
         default: state_d = RST_HOLD;
      endcase
   end

endmodule

// File: rtl/ctrl_transfer_handler.sv
// Control-transfer handler: next-PC select, PC load enable, front-end flush and delay-slot
// annul, with stall-time capture of redirects.
module ctrl_transfer_handler
   import ctrl_transfer_handler_pkg::*;
#(
   parameter int unsigned FLUSH_STAGES = 1,
   parameter int unsigned RESET_HOLD   = 2,
   parameter bit          DELAY_SLOT   = 1'b1
) (
   input  logic                    clk,
   input  logic                    R_n,
   input  logic                    BR,
   input  logic                    BI,
   input  logic                    BA,
   input  logic                    CALL,
   input  logic                    J,
   input  logic                    J_L,
   input  logic                    a_bit,
   input  logic                    stall,
   output logic [1:0]              nPC_sel,
   output logic                    PC_LE,
   output logic [FLUSH_STAGES-1:0] flush,
   output logic                    annul_ds,
   output logic                    busy
);

   logic hold, boot, run;

   ctu_reset_seq #(
      .RESET_HOLD(RESET_HOLD)
   ) u_reset_seq (
      .clk (clk),
      .R_n (R_n),
      .hold(hold),
      .boot(boot),
      .run (run)
   );

   logic [1:0] cur_sel;
   logic       cur_annul, cur_valid;
   logic [1:0] pend_sel_q, pend_sel_d;
   logic       pend_annul_q, pend_annul_d;
   logic       pend_valid_q, pend_valid_d;
   logic [1:0] iss_sel;
   logic       iss_annul;

   // Annul applies to untaken conditional branches and to branch-always with a=1.
   assign cur_annul = BR & a_bit & (~BI | BA);
   assign cur_sel   = (BI | CALL) ? NPC_TAG : ((J | J_L) ? NPC_ALU : NPC_SEQ);
   assign cur_valid = (cur_sel != NPC_SEQ) | cur_annul;

   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         pend_sel_q   <= NPC_SEQ;
         pend_annul_q <= 1'b0;
         pend_valid_q <= 1'b0;
      end else begin
         pend_sel_q   <= pend_sel_d;
         pend_annul_q <= pend_annul_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   always_comb begin
      pend_sel_d   = pend_sel_q;
      pend_annul_d = pend_annul_q;
      pend_valid_d = pend_valid_q;
      iss_sel      = NPC_SEQ;
      iss_annul    = 1'b0;
      nPC_sel      = NPC_SEQ;
      PC_LE        = boot;
      flush        = '1;
      annul_ds     = 1'b0;
      busy         = hold | boot;
      if (run) begin
         flush = '0;
         if (stall) begin
            if (cur_valid) begin
               pend_sel_d   = cur_sel;
               pend_annul_d = cur_annul;
               pend_valid_d = 1'b1;
            end
         end else begin
            PC_LE        = 1'b1;
            pend_valid_d = 1'b0;
            // A fresh request in decode wins over one parked during the stall.
            if (cur_valid) begin
               iss_sel   = cur_sel;
               iss_annul = cur_annul;
            end else if (pend_valid_q) begin
               iss_sel   = pend_sel_q;
               iss_annul = pend_annul_q;
            end
            nPC_sel = iss_sel;
            if (DELAY_SLOT) begin
               flush[0] = iss_annul;
               annul_ds = iss_annul;
            end else begin
               flush[0] = (iss_sel != NPC_SEQ);
            end
         end
      end
   end

endmodule

// File: tb/tb_ctrl_transfer_handler.sv
// Randomized bench for ctrl_transfer_handler: delay-slot and no-delay-slot instances share
// stimulus and are checked against a cycle-count/request-slot reference model.
module tb_ctrl_transfer_handler;

   localparam int RH = 3;

   logic       clk = 1'b0;
   logic       R_n = 1'b0;
   logic       BR = 0, BI = 0, BA = 0, CALL = 0, J = 0, J_L = 0, a_bit = 0, stall = 0;
   logic [1:0] sel_a, sel_b, flush_a, flush_b;
   logic       ple_a, ple_b, ann_a, ann_b, busy_a, busy_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: edges since reset release, plus one parked request slot.
   int edges = 0;
   bit pend_v = 0;
   int pend_kind = 0;
   bit pend_ann = 0;

   always #5 clk = ~clk;

   ctrl_transfer_handler #(
      .FLUSH_STAGES(2), .RESET_HOLD(RH), .DELAY_SLOT(1'b1)
   ) u_dut_ds (
      .clk(clk), .R_n(R_n), .BR(BR), .BI(BI), .BA(BA), .CALL(CALL), .J(J), .J_L(J_L),
      .a_bit(a_bit), .stall(stall), .nPC_sel(sel_a), .PC_LE(ple_a), .flush(flush_a),
      .annul_ds(ann_a), .busy(busy_a)
   );

   ctrl_transfer_handler #(
      .FLUSH_STAGES(2), .RESET_HOLD(RH), .DELAY_SLOT(1'b0)
   ) u_dut_nds (
      .clk(clk), .R_n(R_n), .BR(BR), .BI(BI), .BA(BA), .CALL(CALL), .J(J), .J_L(J_L),
      .a_bit(a_bit), .stall(stall), .nPC_sel(sel_b), .PC_LE(ple_b), .flush(flush_b),
      .annul_ds(ann_b), .busy(busy_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // 0 = none, 1 = TAG target, 2 = ALU target
   function automatic int req_kind();
      if (BI || CALL) return 1;
      if (J || J_L)   return 2;
      return 0;
   endfunction

   function automatic bit req_annul();
      return BR && a_bit && (!BI || BA);
   endfunction

   // Packed as {busy, annul_ds, flush[1:0], PC_LE, nPC_sel[1:0]}
   function automatic logic [6:0] expect_out(input bit ds);
      int   kind;
      bit   ann;
      logic [1:0] sel;
      if (!R_n || edges < RH) return 7'b1_0_11_0_00;
      if (edges == RH)        return 7'b1_0_11_1_00;
      if (stall)              return 7'b0_0_00_0_00;
      kind = req_kind();
      ann  = req_annul();
      if (kind == 0 && !ann && pend_v) begin
         kind = pend_kind;
         ann  = pend_ann;
      end
      sel = (kind == 1) ? 2'b01 : ((kind == 2) ? 2'b10 : 2'b00);
      if (ds) return {1'b0, ann, 1'b0, ann, 1'b1, sel};
      return {1'b0, 1'b0, 1'b0, kind != 0, 1'b1, sel};
   endfunction

   // v = {BR, BI, BA, CALL, J, J_L, a_bit, stall}
   task automatic cycle(input logic rn, input logic [7:0] v, input string tag);
      {BR, BI, BA, CALL, J, J_L, a_bit, stall} = v;
      R_n = rn;
      if (!rn) begin
         edges  = 0;
         pend_v = 0;
         #1;
         check({tag, "/rst_imm"}, {busy_a, ann_a, flush_a, ple_a, sel_a}, 7'b1_0_11_0_00);
      end
      @(negedge clk);
      check({tag, "/ds1"}, {busy_a, ann_a, flush_a, ple_a, sel_a}, expect_out(1'b1));
      check({tag, "/ds0"}, {busy_b, ann_b, flush_b, ple_b, sel_b}, expect_out(1'b0));
      @(posedge clk);
      if (R_n) begin
         if (edges > RH) begin
            if (stall) begin
               if (req_kind() != 0 || req_annul()) begin
                  pend_v    = 1;
                  pend_kind = req_kind();
                  pend_ann  = req_annul();
               end
            end else begin
               pend_v = 0;
            end
         end
         if (edges <= RH) edges++;
      end
      #1;
   endtask

   initial begin
      cycle(1'b0, 8'h00, "reset");
      cycle(1'b0, 8'h01, "reset_stall");
      // Release: RH hold cycles, one BOOT cycle, stall ignored throughout
      for (int i = 0; i < RH + 1; i++) cycle(1'b1, 8'b0000_0101, "boot_seq");
      cycle(1'b1, 8'h00, "run_idle");
      cycle(1'b1, 8'b1000_0010, "annul_untaken");
      cycle(1'b1, 8'b1110_0010, "ba_annul");
      cycle(1'b1, 8'b1110_0000, "ba_no_annul");
      cycle(1'b1, 8'b0000_0101, "stall_jl_1");
      cycle(1'b1, 8'b0000_0101, "stall_jl_2");
      cycle(1'b1, 8'b0000_0000, "stall_release");
      check("release_sel", {30'd0, sel_a}, 32'd0);
      cycle(1'b1, 8'b0000_0000, "after_release");
      cycle(1'b1, 8'b0100_0100, "bi_and_jl");
      cycle(1'b1, 8'b0001_0001, "stall_call");
      cycle(1'b1, 8'b0000_1000, "cur_over_pend");
      cycle(1'b1, 8'b0000_1001, "stall_j");
      cycle(1'b0, 8'b0000_1001, "reset_mid_stall");
      for (int i = 0; i < RH + 1; i++) cycle(1'b1, 8'h00, "reboot");
      cycle(1'b1, 8'h00, "no_redirect_after_boot");

      for (int i = 0; i < 800; i++) begin
         logic [7:0] v;
         logic       rn;
         v    = 8'($urandom);
         v[0] = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) != 0) v[7:1] = 7'($urandom) & 7'($urandom);
         rn   = ($urandom_range(0, 99) != 0);
         cycle(rn, v, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_transfer_handler.md
CTRL_TRANSFER_HANDLER -- requirements
Module: ctrl_transfer_handler

Interface
REQ-001 SHALL have parameter FLUSH_STAGES, default 1: number of front-end pipeline registers under flush control; bit 0 is IF/ID.
REQ-002 SHALL have parameter RESET_HOLD, default 2: cycles the front end is held after reset release; legal range is 1 or greater.
REQ-003 SHALL have parameter DELAY_SLOT, default 1: 1 = SPARC delay-slot/annul semantics; 0 = flush IF/ID on every redirect.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port R_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port BR, input, 1 bit: decode holds a conditional or unconditional branch.
REQ-007 SHALL have port BI, input, 1 bit: branch taken.
REQ-008 SHALL have port BA, input, 1 bit: branch-always opcode.
REQ-009 SHALL have ports CALL, J and J_L, each input, 1 bit: call, jump and jmpl in decode.
REQ-010 SHALL have port a_bit, input, 1 bit: annul bit I[29].
REQ-011 SHALL have port stall, input, 1 bit: hazard-unit freeze request.
REQ-012 SHALL have port nPC_sel, output, 2 bits: 00 = sequential, 01 = TAG target, 10 = ALU target.
REQ-013 SHALL have port PC_LE, output, 1 bit: PC/nPC load enable.
REQ-014 SHALL have port flush, output, FLUSH_STAGES bits: per-stage synchronous clear.
REQ-015 SHALL have port annul_ds, output, 1 bit: the delay-slot instruction is being annulled.
REQ-016 SHALL have port busy, output, 1 bit: the FSM is not in RUN.

Function
REQ-017 SHALL implement the FSM states RST_HOLD, BOOT and RUN.
REQ-018 In RST_HOLD: PC_LE=0, nPC_sel=00, flush all ones, busy=1; the hold counter decrements each cycle; the FSM moves to BOOT on the cycle the counter reaches 0, so it spends exactly RESET_HOLD cycles in RST_HOLD.
REQ-019 In BOOT, lasting one cycle: PC_LE=1, nPC_sel=00, flush all ones, busy=1; the FSM then moves to RUN.
REQ-020 RUN outputs SHALL be combinational from the inputs and pending state, with zero-cycle latency.
REQ-021 Redirect priority in RUN: BI > CALL > (J or J_L); BI or CALL gives nPC_sel=01, J or J_L gives nPC_sel=10, none gives 00.
REQ-022 Annul condition: BR and a_bit and ((not BI) or BA).
REQ-023 With DELAY_SLOT=1: flush[0]=annul_ds=annul condition; taken, non-annulled redirects do not flush.
REQ-024 With DELAY_SLOT=0: flush[0]=1 on any redirect; annul_ds=0.
REQ-025 flush[FLUSH_STAGES-1:1] SHALL be 0 in RUN.
REQ-026 Stall in RUN: PC_LE=0, nPC_sel=00 and flush=0.
REQ-027 Stall in RUN: any redirect/annul request present is captured into the pending register (sel, annul, valid), and the latest request overwrites the previous one.
REQ-028 Stall release: on the first cycle with stall=0, a current request takes precedence over a pending one; otherwise the pending request is issued; pending valid clears on that cycle.
REQ-029 PC_LE SHALL be 1 in RUN whenever stall=0.
REQ-030 stall SHALL be ignored in RST_HOLD and BOOT; no request captures occur in those states.

Reset
REQ-031 R_n low SHALL immediately force: state=RST_HOLD, counter=RESET_HOLD-1, pending cleared, PC_LE=0, nPC_sel=00, flush all ones, annul_ds=0, busy=1.
REQ-032 R_n assertion mid-redirect or mid-stall SHALL discard pending work, with no redirect issued after release.

Structure
REQ-033 A shared package SHALL hold the nPC_sel encodings NPC_SEQ, NPC_TAG and NPC_ALU and the FSM state enum.
REQ-034 The hold counter and the RST_HOLD/BOOT sequencing SHALL be sub-module ctu_reset_seq, with parameter RESET_HOLD and outputs hold, boot and run.
REQ-035 The counter width SHALL be $clog2(RESET_HOLD+1).

Verification
REQ-036 Release R_n with RESET_HOLD=3 -> busy=1, PC_LE=0 for 3 cycles; BOOT for 1 cycle with PC_LE=1 and flush=all ones; then RUN.
REQ-037 RUN with BR=1, BI=0, a_bit=1, DELAY_SLOT=1 -> nPC_sel=00, flush[0]=1, annul_ds=1.
REQ-038 RUN with BR=1, BA=1, BI=1, a_bit=1 -> nPC_sel=01, annul_ds=1; the same stimulus with a_bit=0 -> flush[0]=0.
REQ-039 Raise stall, present J_L=1 for 2 cycles, then drop stall with no request -> nPC_sel=00 during stall, then nPC_sel=10 for one cycle, then 00.
REQ-040 BI=1 and J_L=1 together with DELAY_SLOT=0 -> nPC_sel=01, flush[0]=1.
REQ-041 Assert R_n low while stall=1 with a request pending -> outputs at reset values immediately; no redirect after BOOT.
